sha3_digest_reader: RTL and testbench
=====================================

# sha3_digest_reader

Output-side companion to the SHA-3 low-throughput core: captures the 512-bit digest when the core's `out_ready` rises and streams it out as sixteen 32-bit words over a valid/ready handshake. It also folds the words into a 32-bit signature and counts delivered digests, so OOC bitstream builds keep the full digest path live without routing 512 pins. It sits directly after `sha3_low_throughput` in the random-stimulus OOC top, taking `out`/`out_ready`.

## Interface
- `DIGEST_W`, 512, digest width in bits; must be a multiple of `WORD_W`.
- `WORD_W`, 32, output word width.
- `NUM_WORDS`, `DIGEST_W/WORD_W` (16), derived; not overridden.

- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = in reset).
- `digest_in`  in  DIGEST_W  digest from core `out`.
- `digest_valid`  in  1  core `out_ready`; level, held high while the digest is valid.
- `word_out`  out  WORD_W  current word; word 0 = `digest_in[511:480]`, MS word first.
- `word_valid`  out  1  `word_out` is valid.
- `word_ready`  in  1  downstream accepts; transfer when `word_valid & word_ready`.
- `word_last`  out  1  high with `word_valid` on word 15.
- `busy`  out  1  high in SEND.
- `overrun`  out  1  sticky; a new digest arrived while busy.
- `signature`  out  WORD_W  rotate-XOR fold of accepted words of the current/last digest.
- `digest_count`  out  8  number of fully delivered digests, wraps 255→0.

## Operation
- Edge detect: register `dv_q`. A capture event is `digest_valid & ~dv_q`.
- States: IDLE, SEND.
- IDLE + capture event: load shift register with `digest_in`, index←0, signature←0, go to SEND.
- SEND: `word_valid`=1, `word_out` = top word of the shift register. On transfer: shift left by `WORD_W`, index+1, `signature ← rotl1(signature) ^ word_out`.
- Transfer with index=15 (`word_last`): `digest_count`+1 (mod 256), go to IDLE.
- Capture event in SEND, not on the final transfer: digest dropped, `overrun`←1, stream continues unchanged.
- Capture event on the same cycle as the final transfer: accepted. Reload, index←0, signature←0, stay in SEND. No overrun. `digest_count` still increments.
- `overrun` clears only on reset.
- `word_out`, `word_last` hold stable while `word_valid & ~word_ready` (no stall-driven change).
- `signature` is stable in IDLE and reflects the last completed digest.

## Timing
- Reset values: `word_out`=0, `word_valid`=0, `word_last`=0, `busy`=0, `overrun`=0, `signature`=0, `digest_count`=0, state IDLE, index 0, shift register 0.
- `dv_q` resets to 1. A digest already held high at reset release is not re-sent; only a later 0→1 transition captures.
- Latency: capture event sampled at edge N, then `word_valid`/`busy` high after edge N (visible cycle N+1).
- Throughput: one word per cycle with `word_ready` tied high, so 16 cycles per digest. `busy` falls the cycle after the final transfer unless reloaded.
- Reset asserted mid-stream: all outputs go to reset values immediately (async); the partial digest is discarded and not counted.
- `digest_in` is sampled only at capture; later changes are ignored.

## Structure
- Package `sha3_reader_pkg`: state enum `reader_state_t` {IDLE, SEND}, `DIGEST_W`/`WORD_W` defaults, the `rotl1` function.
- One sub-module: `digest_shift_reg`, a parallel-load, word-shift register exposing the top word. FSM, index counter, signature and counters live in `sha3_digest_reader`.

## Test plan
- Word order: digest words `0x00000000`…`0x0000000F` (word i = i), `word_ready`=1, then `word_out` sequence 0..15 on 16 consecutive cycles, `word_last` only on 15, `digest_count`=1.
- Signature: word0=`0x80000000`, others 0, then `signature`=`0x00004000` after completion. All-zero digest gives `signature`=0.
- Backpressure: `word_ready` low 3 cycles at word 5, then `word_out` stays at word 5, no skips or duplicates, and 16 transfers total.
- Overrun: second 0→1 on `digest_valid` at word 7, then `overrun`=1 and the first digest completes intact. A capture coincident with the final transfer reloads with `overrun`=0 and `digest_count`=2.
- Reset: `reset`=0 at word 9, then outputs return to reset values at once, `digest_count`=0. `digest_valid` held high through release produces no capture.
- Wrap: 256 digests, then `digest_count` = 0.

Source files
------------

// File: rtl/sha3_reader_pkg.sv
// Shared types and helpers for the SHA-3 digest reader.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sha3_reader_pkg;

  // Default geometry: 512-bit digest streamed as 32-bit words.
  localparam int DIGEST_W_DEF = 512;
  localparam int WORD_W_DEF   = 32;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } reader_state_t;

  // Rotate left by one bit, used to fold words into the signature.
  function automatic logic [WORD_W_DEF-1:0] rotl1(input logic [WORD_W_DEF-1:0] x);
    return {x[WORD_W_DEF-2:0], x[WORD_W_DEF-1]};
  endfunction

endpackage

// File: rtl/sha3_digest_reader_shift_reg.sv
// Parallel-load word-shift register; the top word is presented continuously.
// Latency: load or shift takes effect on the next rising edge.
// Backpressure: none internally; the caller only pulses shift on accepted words.
module digest_shift_reg #(
  parameter int DIGEST_W = 512,
  parameter int WORD_W   = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [DIGEST_W-1:0] load_data,
  input  logic                shift,
  output logic [WORD_W-1:0]   top_word
);

  logic [DIGEST_W-1:0] data;

  // Load wins over shift so a reload coinciding with the final word starts clean.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data <= '0;
    end else if (load) begin
      data <= load_data;
    end else if (shift) begin
      data <= {data[DIGEST_W-WORD_W-1:0], {WORD_W{1'b0}}};
    end
  end

  assign top_word = data[DIGEST_W-1 -: WORD_W];

endmodule

// File: rtl/sha3_digest_reader.sv
// Captures a digest on the rising edge of digest_valid and streams it MS word first.
// Latency: word_valid rises the cycle after the capturing edge; one word per cycle.
// Backpressure: word_ready low holds word_out/word_last stable; no words are skipped.
module sha3_digest_reader
  import sha3_reader_pkg::*;
#(
  parameter int DIGEST_W = DIGEST_W_DEF,
  parameter int WORD_W   = WORD_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DIGEST_W-1:0] digest_in,
  input  logic                digest_valid,
  output logic [WORD_W-1:0]   word_out,
  output logic                word_valid,
  input  logic                word_ready,
  output logic                word_last,
  output logic                busy,
  output logic                overrun,
  output logic [WORD_W-1:0]   signature,
  output logic [7:0]          digest_count
);

  localparam int NUM_WORDS = DIGEST_W / WORD_W;
  localparam int IDX_W     = $clog2(NUM_WORDS);
  // Index of the word just before the last one: transferring it exposes word_last.
  localparam logic [IDX_W-1:0] PENULT_IDX = IDX_W'(NUM_WORDS - 2);

  reader_state_t    state;
  logic [IDX_W-1:0] index;
  logic             dv_q;
  logic             capture;
  logic             transfer;
  logic             final_xfer;
  logic             load;

  // A capture is a 0->1 transition of the core's level-style valid.
  assign capture    = digest_valid & ~dv_q;
  assign transfer   = word_valid & word_ready;
  assign final_xfer = transfer & word_last;
  // New digest is taken when idle, or when it lands exactly on the final transfer.
  assign load       = capture & ((state == IDLE) | final_xfer);
  assign busy       = (state == SEND);

  // Edge-detect register resets high so a digest held across reset release is ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dv_q <= 1'b1;
    end else begin
      dv_q <= digest_valid;
    end
  end

  digest_shift_reg #(
    .DIGEST_W (DIGEST_W),
    .WORD_W   (WORD_W)
  ) u_shift (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_data (digest_in),
    .shift     (transfer),
    .top_word  (word_out)
  );

  // Stream control: state, word index, registered handshake outputs, signature and counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      index        <= '0;
      word_valid   <= 1'b0;
      word_last    <= 1'b0;
      overrun      <= 1'b0;
      signature    <= '0;
      digest_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (capture) begin
            state      <= SEND;
            index      <= '0;
            signature  <= '0;
            word_valid <= 1'b1;
            word_last  <= 1'b0;
          end
        end
        SEND: begin
          // A digest arriving mid-stream is dropped and flagged; the stream carries on.
          if (capture && !final_xfer) begin
            overrun <= 1'b1;
          end
          if (transfer) begin
            signature <= rotl1(signature) ^ word_out;
            index     <= index + IDX_W'(1);
            word_last <= (index == PENULT_IDX);
            if (word_last) begin
              digest_count <= digest_count + 8'd1;
              word_last    <= 1'b0;
              if (capture) begin
                // Back-to-back digest: restart the stream without leaving SEND.
                index     <= '0;
                signature <= '0;
              end else begin
                state      <= IDLE;
                word_valid <= 1'b0;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha3_digest_reader.sv
// Directed bench for sha3_digest_reader with a queue-based reference model.
// Latency: checks outputs every falling edge against the model.
// Backpressure: exercises word_ready stalls, overrun and back-to-back reload.
module tb_sha3_digest_reader;

  localparam int DW = 512;
  localparam int WW = 32;
  localparam int NW = DW / WW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] digest_in = '0;
  logic          digest_valid = 1'b0;
  logic          word_ready = 1'b1;
  logic [WW-1:0] word_out;
  logic          word_valid;
  logic          word_last;
  logic          busy;
  logic          overrun;
  logic [WW-1:0] signature;
  logic [7:0]    digest_count;

  sha3_digest_reader #(
    .DIGEST_W (DW),
    .WORD_W   (WW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .digest_in    (digest_in),
    .digest_valid (digest_valid),
    .word_out     (word_out),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .word_last    (word_last),
    .busy         (busy),
    .overrun      (overrun),
    .signature    (signature),
    .digest_count (digest_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of words still owed for the digest in flight.
  logic [WW-1:0] m_q[$];
  logic          m_busy = 1'b0;
  logic [WW-1:0] m_sig = '0;
  logic [7:0]    m_cnt = '0;
  logic          m_ovr = 1'b0;
  logic          m_dvq = 1'b1;
  logic          m_cap;

  function automatic logic [WW-1:0] rot(input logic [WW-1:0] x);
    return (x << 1) | (x >> (WW - 1));
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      m_busy = 1'b0;
      m_sig  = '0;
      m_cnt  = '0;
      m_ovr  = 1'b0;
      m_dvq  = 1'b1;
    end else begin
      m_cap = digest_valid & ~m_dvq;
      m_dvq = digest_valid;
      if (m_busy && word_ready) begin
        m_sig = rot(m_sig) ^ m_q[0];
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin
          m_cnt  = m_cnt + 8'd1;
          m_busy = 1'b0;
        end
      end
      if (m_cap) begin
        if (!m_busy) begin
          m_q.delete();
          for (int i = 0; i < NW; i++) m_q.push_back(digest_in[DW-1-WW*i -: WW]);
          m_sig  = '0;
          m_busy = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end
    end
  end

  // Observed transfers and word_last sightings, for literal checks.
  logic [WW-1:0] log_q[$];
  int            n_last = 0;

  // Compare process: every falling edge, DUT outputs against the model.
  always @(negedge clk) begin
    if (!reset) begin
      check("rst_word_out", word_out, 0);
      check("rst_word_valid", word_valid, 0);
      check("rst_word_last", word_last, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);
      check("rst_signature", signature, 0);
      check("rst_count", digest_count, 0);
    end else begin
      check("word_valid", word_valid, m_busy);
      check("busy", busy, m_busy);
      check("overrun", overrun, m_ovr);
      check("signature", signature, m_sig);
      check("digest_count", digest_count, m_cnt);
      if (m_busy) begin
        check("word_out", word_out, m_q[0]);
        check("word_last", word_last, (m_q.size() == 1));
      end else begin
        check("word_last_idle", word_last, 0);
      end
      if (word_valid && word_ready) log_q.push_back(word_out);
      if (word_valid && word_last) n_last++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] mk(input logic [WW-1:0] base);
    logic [DW-1:0] d;
    d = '0;
    for (int i = 0; i < NW; i++) d[DW-1-WW*i -: WW] = base + WW'(i);
    return d;
  endfunction

  task automatic send(input logic [DW-1:0] d);
    digest_in    = d;
    digest_valid = 1'b1;
    step();
    digest_valid = 1'b0;
    digest_in    = ~d;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 64 && busy; k++) step();
    check("idle_timeout", busy, 0);
  endtask

  task automatic wait_word(input logic [WW-1:0] w);
    for (int k = 0; k < 40 && !(word_valid && word_out == w); k++) step();
    check("reach_word", word_out, w);
  endtask

  task automatic check_log(input string name, input logic [WW-1:0] base);
    check({name, "_len"}, log_q.size(), NW);
    for (int i = 0; i < NW; i++)
      check(name, (i < log_q.size()) ? log_q[i] : 32'hDEAD_BEEF, base + WW'(i));
  endtask

  initial begin
    logic [DW-1:0] sig_d;
    repeat (3) step();
    check("lit_rst_valid", word_valid, 0);
    check("lit_rst_count", digest_count, 0);
    reset = 1'b1;
    repeat (2) step();

    // Word order
    log_q.delete();
    n_last = 0;
    send(mk(32'h0));
    check("latency_valid", word_valid, 1);
    check("first_word", word_out, 32'h0);
    wait_idle();
    check_log("order", 32'h0);
    check("order_last_once", n_last, 1);
    check("order_count", digest_count, 1);

    // Signature
    sig_d = '0;
    sig_d[DW-1 -: WW] = 32'h8000_0000;
    send(sig_d);
    wait_idle();
    check("sig_single_bit", signature, 32'h0000_4000);
    send('0);
    wait_idle();
    check("sig_zero", signature, 0);
    check("sig_count", digest_count, 3);

    // Backpressure at word 5
    log_q.delete();
    send(mk(32'h100));
    wait_word(32'h105);
    word_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_hold_word", word_out, 32'h105);
      check("bp_hold_valid", word_valid, 1);
    end
    word_ready = 1'b1;
    wait_idle();
    check_log("bp", 32'h100);
    check("bp_count", digest_count, 4);

    // Overrun at word 7
    log_q.delete();
    send(mk(32'h200));
    wait_word(32'h207);
    digest_in    = mk(32'h900);
    digest_valid = 1'b1;
    step();
    digest_valid = 1'b0;
    check("ovr_set", overrun, 1);
    wait_idle();
    check_log("ovr", 32'h200);
    check("ovr_count", digest_count, 5);
    check("ovr_sticky", overrun, 1);

    // Reset mid-stream at word 9
    send(mk(32'h300));
    wait_word(32'h309);
    #2;
    reset = 1'b0;
    #1;
    check("arst_valid", word_valid, 0);
    check("arst_word", word_out, 0);
    check("arst_busy", busy, 0);
    check("arst_overrun", overrun, 0);
    check("arst_count", digest_count, 0);
    digest_in    = mk(32'h500);
    digest_valid = 1'b1;
    step();
    step();
    reset = 1'b1;
    repeat (4) step();
    check("no_capture_at_release", busy, 0);
    digest_valid = 1'b0;
    step();

    // Capture coincident with final transfer
    log_q.delete();
    send(mk(32'h400));
    for (int k = 0; k < 40 && !word_last; k++) step();
    check("reach_last", word_last, 1);
    digest_in    = mk(32'h600);
    digest_valid = 1'b1;
    step();
    digest_valid = 1'b0;
    check("reload_busy", busy, 1);
    check("reload_overrun", overrun, 0);
    check("reload_word", word_out, 32'h600);
    check("reload_sig", signature, 0);
    check("reload_count", digest_count, 1);
    wait_idle();
    check("reload_count2", digest_count, 2);
    check("reload_len", log_q.size(), 2 * NW);
    check("reload_seam", (log_q.size() > NW) ? log_q[NW] : 32'hDEAD_BEEF, 32'h600);

    // Count wrap
    for (int k = 0; k < 254; k++) begin
      send(mk(WW'(k) << 8));
      wait_idle();
    end
    check("wrap_count", digest_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
